// File: rtl/data_c_pkg.sv
// Shared definitions for the data_c stream FIFO family.
//   fifo_mode_e : read-mode selector (registered output or fall-through)
//   ptr_w()     : storage pointer width, one extra wrap bit over the address
//   cnt_w()     : occupancy counter width, able to hold DEPTH+2
package data_c_pkg;

    typedef enum logic {
        FIFO_REG_OUT = 1'b0,
        FIFO_FWFT    = 1'b1
    } fifo_mode_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // DEPTH+3 so the largest occupancy (DEPTH+2) still fits when DEPTH+2
    // happens to be a power of two (DEPTH=2).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/data_c_sync_fifo_mem.sv
// Simple dual-port storage array for data_c_sync_fifo.
// Synchronous write, asynchronous read, no reset on contents.
// Ports:
//   clock   : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data at rd_addr
module data_c_sync_fifo_mem
    import data_c_pkg::*;
#(
    parameter int DSIZE = 18,
    parameter int DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          wr_en,
    input  logic [ptr_w(DEPTH)-2:0]       wr_addr,
    input  logic [DSIZE-1:0]              wr_data,
    input  logic [ptr_w(DEPTH)-2:0]       rd_addr,
    output logic [DSIZE-1:0]              rd_data
);

    logic [DSIZE-1:0] ram [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    assign rd_data = ram[rd_addr];

endmodule

// File: rtl/data_c_sync_fifo.sv
// Single-clock valid/ready stream FIFO with occupancy count, almost
// flags and synchronous flush.
// FWFT=1: one output register after the memory, latency 1, capacity DEPTH+1.
// FWFT=0: two output registers, latency 2, capacity DEPTH+2.
// Ports:
//   clock        : sole clock
//   rst          : asynchronous active-high reset
//   flush        : synchronous clear of all contents (highest priority)
//   in_data      : write data
//   in_valid     : write request
//   in_ready     : space available in the memory
//   out_data     : read data, stable while out_valid && !out_ready
//   out_valid    : read data present
//   out_ready    : consumer accept
//   count        : entries held, output registers included
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
module data_c_sync_fifo
    import data_c_pkg::*;
#(
    parameter  int DSIZE    = 18,
    parameter  int DEPTH    = 8,
    parameter  int FWFT     = 1,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 1,
    localparam int CSIZE    = cnt_w(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             flush,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CSIZE-1:0] count,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int AW    = PTR_W - 1;
    localparam bit FALL_THROUGH = (FWFT == int'(FIFO_FWFT));
    localparam logic [CSIZE-1:0] AF_C = CSIZE'(AF_LEVEL);
    localparam logic [CSIZE-1:0] AE_C = CSIZE'(AE_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("data_c_sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL > DEPTH + 1 + (FALL_THROUGH ? 0 : 1)) begin : g_bad_af
        $error("data_c_sync_fifo: AF_LEVEL exceeds FIFO capacity");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
        $error("data_c_sync_fifo: AE_LEVEL must be below AF_LEVEL");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             mem_empty;
    logic             mem_full;
    logic             ready_en;
    logic             wr_en;
    logic             out_fire;
    logic             mem_wr;
    logic [DSIZE-1:0] mem_rd_data;

    // Head stage: the register fed straight from memory (or bypass).
    logic             vld_p0;
    logic [DSIZE-1:0] data_p0;
    logic             drain_p0;
    logic             take_p0;
    logic             load_mem_p0;
    logic             load_byp_p0;

    logic [CSIZE-1:0] count_next;

    // Wrap bit differs and address bits match: the memory holds DEPTH words.
    assign mem_empty = (wr_ptr == rd_ptr);
    assign mem_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Depends only on registers, so out_ready never reaches in_ready.
    assign in_ready = ready_en && !mem_full;
    assign wr_en    = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // A word only enters the memory when it cannot go straight to the head.
    assign take_p0     = !vld_p0 || drain_p0;
    assign load_mem_p0 = take_p0 && !mem_empty;
    assign load_byp_p0 = take_p0 && mem_empty && wr_en;
    assign mem_wr      = wr_en && !load_byp_p0 && !flush;

    data_c_sync_fifo_mem #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_wr),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    // ---- pointers and ready enable ----
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (mem_wr) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (load_mem_p0) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // ---- stage p0: memory / bypass -> head register ----
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (take_p0) begin
            vld_p0 <= load_mem_p0 || load_byp_p0;
            if (load_mem_p0) begin
                data_p0 <= mem_rd_data;
            end else if (load_byp_p0) begin
                data_p0 <= in_data;
            end
        end
    end

    if (FALL_THROUGH) begin : g_fwft
        assign drain_p0  = out_fire;
        assign out_valid = vld_p0;
        assign out_data  = data_p0;
    end else begin : g_reg_out
        logic             vld_p1;
        logic [DSIZE-1:0] data_p1;
        logic             take_p1;

        // p1 refills from p0 whenever it is empty or being read.
        assign take_p1  = !vld_p1 || out_fire;
        assign drain_p0 = take_p1;

        // ---- stage p1: head register -> output register ----
        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
            end else if (flush) begin
                vld_p1 <= 1'b0;
            end else if (take_p1) begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    data_p1 <= data_p0;
                end
            end
        end

        assign out_valid = vld_p1;
        assign out_data  = data_p1;
    end

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_en, out_fire})
                2'b10:   count_next = count + CSIZE'(1);
                2'b01:   count_next = count - CSIZE'(1);
                default: count_next = count;
            endcase
        end
    end

    // ---- occupancy and flags, flags from next count to stay aligned ----
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_next;
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
        end
    end

endmodule

// File: tb/tb_data_c_sync_fifo.sv
module tb_data_c_sync_fifo;

    localparam int DW  = 18;
    localparam int DEP = 8;
    localparam int AF  = DEP - 2;
    localparam int AE  = 1;

    logic          clock = 1'b0;
    logic          rst   = 1'b0;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          out_ready;

    logic [1:0]    o_ready;
    logic [1:0]    o_valid;
    logic [1:0]    o_af;
    logic [1:0]    o_ae;
    logic [DW-1:0] o_data  [2];
    logic [3:0]    o_count [2];

    always #5 clock = ~clock;

    // Instance 0: fall-through, instance 1: registered output.
    data_c_sync_fifo #(.DSIZE(DW), .DEPTH(DEP), .FWFT(1)) dut (
        .clock(clock), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(o_ready[0]),
        .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
        .count(o_count[0]), .almost_full(o_af[0]), .almost_empty(o_ae[0])
    );

    data_c_sync_fifo #(.DSIZE(DW), .DEPTH(DEP), .FWFT(0)) dut0 (
        .clock(clock), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(o_ready[1]),
        .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
        .count(o_count[1]), .almost_full(o_af[1]), .almost_empty(o_ae[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each FIFO is an ordered list of (word, accept cycle). The head is
    // visible once its latency has elapsed; space exists while the list is
    // below capacity.
    int            lat [2] = '{1, 2};
    int            cap [2] = '{DEP + 1, DEP + 2};
    logic [DW-1:0] md  [2][16];
    int            mt  [2][16];
    int            msize [2] = '{0, 0};
    int            cyc   = 0;
    bit            alive = 1'b0;
    bit            held  [2] = '{1'b0, 1'b0};
    logic [DW-1:0] last_data [2];
    int            npop0 = 0;

    function automatic bit exp_valid(input int m);
        return (msize[m] > 0) && (mt[m][0] + lat[m] <= cyc);
    endfunction

    function automatic bit exp_ready(input int m);
        return alive && (msize[m] < cap[m]);
    endfunction

    function automatic void push(input int m, input logic [DW-1:0] d, input int t);
        md[m][msize[m]] = d;
        mt[m][msize[m]] = t;
        msize[m]++;
    endfunction

    function automatic void pop(input int m);
        for (int k = 0; k < 15; k++) begin
            md[m][k] = md[m][k+1];
            mt[m][k] = mt[m][k+1];
        end
        msize[m]--;
        if (m == 0) npop0++;
    endfunction

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                msize[m] = 0;
                held[m]  = 1'b0;
            end
            alive = 1'b0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit v;
                bit r;
                v = exp_valid(m);
                r = exp_ready(m);
                held[m] = v && !out_ready && !flush;
                if (flush) begin
                    msize[m] = 0;
                end else begin
                    if (v && out_ready) pop(m);
                    if (in_valid && r) push(m, in_data, cyc);
                end
            end
            alive = 1'b1;
            cyc++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("out_valid[%0d]", m), 32'(o_valid[m]), 32'(exp_valid(m)));
            if (exp_valid(m))
                chk($sformatf("out_data[%0d]", m), 32'(o_data[m]), 32'(md[m][0]));
            if (held[m])
                chk($sformatf("hold_data[%0d]", m), 32'(o_data[m]), 32'(last_data[m]));
            chk($sformatf("in_ready[%0d]", m), 32'(o_ready[m]), 32'(exp_ready(m)));
            chk($sformatf("count[%0d]", m), 32'(o_count[m]), 32'(msize[m]));
            chk($sformatf("almost_full[%0d]", m), 32'(o_af[m]), 32'(msize[m] >= AF));
            chk($sformatf("almost_empty[%0d]", m), 32'(o_ae[m]), 32'(msize[m] <= AE));
            last_data[m] = o_data[m];
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int start;
        int n;

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();

        // Reset state
        for (int m = 0; m < 2; m++) begin
            chk("rst_in_ready", 32'(o_ready[m]), 32'd0);
            chk("rst_out_valid", 32'(o_valid[m]), 32'd0);
            chk("rst_count", 32'(o_count[m]), 32'd0);
            chk("rst_almost_empty", 32'(o_ae[m]), 32'd1);
            chk("rst_almost_full", 32'(o_af[m]), 32'd0);
            chk("rst_out_data", 32'(o_data[m]), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready0", 32'(o_ready[0]), 32'd1);
        chk("post_rst_in_ready1", 32'(o_ready[1]), 32'd1);

        // Single word
        in_valid = 1'b1;
        in_data  = 18'h155;
        tick();
        in_valid = 1'b0;
        chk("single_valid", 32'(o_valid[0]), 32'd1);
        chk("single_data", 32'(o_data[0]), 32'h155);
        chk("single_count", 32'(o_count[0]), 32'd1);
        chk("single_ae", 32'(o_ae[0]), 32'd1);
        chk("single_regout_valid_c1", 32'(o_valid[1]), 32'd0);
        tick();
        chk("single_regout_valid_c2", 32'(o_valid[1]), 32'd1);
        chk("single_regout_data", 32'(o_data[1]), 32'h155);
        idle(4);

        // FWFT=0 latency from empty
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 18'h3;
        tick();
        in_valid = 1'b0;
        chk("lat2_c1_valid", 32'(o_valid[1]), 32'd0);
        tick();
        chk("lat2_c2_valid", 32'(o_valid[1]), 32'd1);
        chk("lat2_c2_data", 32'(o_data[1]), 32'h3);
        idle(4);

        // Fill with out_ready low
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            if (o_ready[0]) acc++;
            tick();
            chk("fill_count", 32'(o_count[0]), 32'((i < 9) ? i + 1 : 9));
            chk("fill_af", 32'(o_af[0]), 32'(i >= 5));
        end
        in_valid = 1'b0;
        chk("fill_accepts", 32'(acc), 32'd9);
        chk("fill_in_ready", 32'(o_ready[0]), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("drain_valid", 32'(o_valid[0]), 32'd1);
            chk("drain_data", 32'(o_data[0]), 32'(k));
            tick();
        end
        chk("drain_empty", 32'(o_valid[0]), 32'd0);
        idle(4);

        // Full-throughput streaming
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(18'h1000 + i);
            tick();
            chk("stream_count", 32'(o_count[0]), 32'd1);
            chk("stream_data", 32'(o_data[0]), 32'(18'h1000 + i));
        end
        idle(4);

        // Flush
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(18'h10 + i);
            tick();
        end
        chk("pre_flush_count", 32'(o_count[0]), 32'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 18'hAA;
        chk("flush_in_ready", 32'(o_ready[0]), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(o_count[0]), 32'd0);
        chk("flush_valid", 32'(o_valid[0]), 32'd0);
        chk("flush_ae", 32'(o_ae[0]), 32'd1);
        chk("flush_count_regout", 32'(o_count[1]), 32'd0);
        in_valid = 1'b1;
        in_data  = 18'h01;
        tick();
        in_valid = 1'b0;
        chk("after_flush_data", 32'(o_data[0]), 32'h01);
        chk("after_flush_valid", 32'(o_valid[0]), 32'd1);
        idle(4);

        // Reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(18'h200 + i);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("midrst_valid", 32'(o_valid[m]), 32'd0);
            chk("midrst_count", 32'(o_count[m]), 32'd0);
            chk("midrst_in_ready", 32'(o_ready[m]), 32'd0);
        end
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_release_in_ready0", 32'(o_ready[0]), 32'd1);
        chk("rst_release_in_ready1", 32'(o_ready[1]), 32'd1);

        // Random traffic with backpressure and rare flush
        start = npop0;
        n = 0;
        while ((npop0 - start < 500) && (n < 5000)) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            tick();
            n++;
        end
        chk("random_500_words", 32'(npop0 - start >= 500), 32'd1);
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
